// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the EMAC TX arbiter and related sharing logic.
package eth_tx_pkg;

   localparam int unsigned ETH_MAX_FRAME = 1514;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WAIT_ACK = 3'd1;
   localparam logic [2:0] ST_STREAM   = 3'd2;
   localparam logic [2:0] ST_END      = 3'd3;
   localparam logic [2:0] ST_GAP      = 3'd4;

   // Bits needed to hold values 0..max_val (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: one-hot pick of the first request after the
// last winner, with the pointer advanced only when the caller takes the grant.
module rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   input  logic         update_i,
   output logic [N-1:0] gnt_c_o
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] idx_c, win_c;
   logic          found_c;

   // Scan from last+1 with wrap; first asserted request wins.
   always_comb begin
      gnt_c_o = '0;
      win_c   = last_q;
      idx_c   = last_q;
      found_c = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx_c = IW'((32'(last_q) + k) % N);
         if (!found_c && req_i[idx_c]) begin
            found_c = 1'b1;
            win_c   = idx_c;
         end
      end
      if (found_c) gnt_c_o[win_c] = 1'b1;
      last_d = (update_i && found_c) ? win_c : last_q;
   end

   // Pointer starts at N-1 so requester 0 is favoured after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= IW'(N - 1);
      else        last_q <= last_d;
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Per-frame round-robin sharing of the EMAC client TX byte interface.
// Optional statistics counters are built when ETH_TX_ARB_STATS_EN is defined.
module eth_tx_arbiter
   import eth_tx_pkg::*;
#(
   parameter int unsigned N_REQ      = 2,
   parameter int unsigned IFG_CYCLES = 4,
   parameter int unsigned MAX_LEN    = ETH_MAX_FRAME
) (
   input  logic                 tx_clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     grant,
   output logic [7:0]           tx_data,
   output logic                 tx_data_en,
   input  logic                 tx_ack,
   output logic                 tx_underrun,
   output logic                 busy
`ifdef ETH_TX_ARB_STATS_EN
  ,output logic [16*N_REQ-1:0]  frame_cnt,
   output logic [15:0]          underrun_cnt
`endif
);

   localparam int unsigned CW       = cnt_width(MAX_LEN);
   localparam int unsigned GW       = cnt_width(IFG_CYCLES);
   localparam int unsigned GAP_LOAD = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

   logic [2:0]       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             tx_en_q, tx_en_d;
   logic             busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [GW-1:0]    gap_q, gap_d;

   logic [N_REQ-1:0] arb_gnt_c;
   logic             arb_take_c;
   logic             valid_g_c, last_g_c, maxed_c, underrun_c;

   assign valid_g_c  = |(req_valid & grant_q);
   assign last_g_c   = |(req_last & grant_q);
   assign maxed_c    = (cnt_q >= CW'(MAX_LEN));
   assign arb_take_c = (state_q == ST_IDLE) && (|req_valid);

   rr_arbiter #(.N(N_REQ)) u_rr (
      .clk      (tx_clk),
      .rst_n    (rst_n),
      .req_i    (req_valid),
      .update_i (arb_take_c),
      .gnt_c_o  (arb_gnt_c)
   );

   // Byte is taken on ack in WAIT_ACK and every STREAM cycle short of the length cap.
   assign req_ready = grant_q & {N_REQ{((state_q == ST_WAIT_ACK) && tx_ack) ||
                                       ((state_q == ST_STREAM) && !maxed_c)}};

   // Underrun is flagged alongside the offending beat while TXDVLD is still high.
   assign tx_underrun = underrun_c;
   assign grant       = grant_q;
   assign tx_data_en  = tx_en_q;
   assign busy        = busy_q;

   // Data mux selected by the registered one-hot grant; zero when nobody owns the MAC.
   always_comb begin
      tx_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) tx_data = tx_data | req_data[8*i +: 8];
      end
   end

   // Next-state and registered-output logic for the frame FSM.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      underrun_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               grant_d = arb_gnt_c;
               cnt_d   = '0;
               state_d = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (tx_ack) begin
               cnt_d   = CW'(1);
               state_d = last_g_c ? ST_END : ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (maxed_c) begin
               underrun_c = 1'b1;
               state_d    = ST_END;
            end else if (!valid_g_c) begin
               underrun_c = 1'b1;
               state_d    = ST_END;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (last_g_c) state_d = ST_END;
            end
         end
         ST_END: begin
            if (IFG_CYCLES == 0) begin
               state_d = ST_IDLE;
            end else begin
               gap_d   = GW'(GAP_LOAD);
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q == '0) state_d = ST_IDLE;
            else             gap_d   = gap_q - GW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_END) grant_d = '0;
      tx_en_d = (state_d == ST_WAIT_ACK) || (state_d == ST_STREAM);
      busy_d  = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         tx_en_q <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         tx_en_q <= tx_en_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
      end
   end

`ifdef ETH_TX_ARB_STATS_EN
   logic [N_REQ-1:0][15:0] frame_cnt_q;
   logic [15:0]            underrun_cnt_q;
   logic                   frame_ok_c;

   assign frame_ok_c = ((state_q == ST_WAIT_ACK) && tx_ack && last_g_c) ||
                       ((state_q == ST_STREAM) && !maxed_c && valid_g_c && last_g_c);

   // Per-owner completed-frame count and global underrun count, both wrapping.
   always_ff @(posedge tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q    <= '0;
         underrun_cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (frame_ok_c && grant_q[i]) frame_cnt_q[i] <= frame_cnt_q[i] + 16'd1;
         end
         if (underrun_c) underrun_cnt_q <= underrun_cnt_q + 16'd1;
      end
   end

   assign frame_cnt    = frame_cnt_q;
   assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter with a small per-requester source model.
module tb_eth_tx_arbiter;

   localparam int N = 2;
   localparam int unsigned NONE = 32'hFFFF_FFFF;

   logic            tx_clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [8*N-1:0]  req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    grant;
   logic [7:0]      tx_data;
   logic            tx_data_en;
   logic            tx_ack;
   logic            tx_underrun;
   logic            busy;
`ifdef ETH_TX_ARB_STATS_EN
   logic [16*N-1:0] frame_cnt;
   logic [15:0]     underrun_cnt;
`endif

   eth_tx_arbiter #(.N_REQ(N), .IFG_CYCLES(4), .MAX_LEN(1514)) dut (
      .tx_clk      (tx_clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .grant       (grant),
      .tx_data     (tx_data),
      .tx_data_en  (tx_data_en),
      .tx_ack      (tx_ack),
      .tx_underrun (tx_underrun),
      .busy        (busy)
`ifdef ETH_TX_ARB_STATS_EN
     ,.frame_cnt   (frame_cnt),
      .underrun_cnt(underrun_cnt)
`endif
   );

   initial begin
      tx_clk = 1'b0;
      forever #5 tx_clk = ~tx_clk;
   end

   int n_vec = 0;
   int n_err = 0;

   // Source model state.
   int unsigned pos[N], len[N], drop_at[N], frames_left[N];
   bit          active[N], no_last[N];
   int          ack_delay, en_cnt;
   bit          acked;

   // Per-cycle samples and accumulated observations.
   logic        s_en, s_ur, s_busy;
   logic [7:0]  s_data;
   logic [N-1:0] s_rdy, s_grant, s_valid;
   int n_en, n_busy, n_ur, n_bad, n_wait, min_gap, low_run, frame_bytes;
   int n_rdy[N], n_cons[N];
   int ur_en, ur_rdy, after_ur_en;
   bit prev_en, seen_frame, ur_pending;
   logic [N-1:0] glog[$];

   function automatic logic [7:0] byte_of(input int i, input int unsigned p);
      return 8'(p * 7 + 32'(i) * 64 + 3);
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bit v;
         v = active[i] && (pos[i] < len[i]) && (pos[i] != drop_at[i]);
         req_valid[i]       = v;
         req_data[8*i +: 8] = byte_of(i, pos[i]);
         req_last[i]        = v && !no_last[i] && (pos[i] == len[i] - 1);
      end
   endtask

   task automatic clear_stats();
      n_en = 0; n_busy = 0; n_ur = 0; n_bad = 0; n_wait = 0;
      min_gap = 1000; low_run = 0; frame_bytes = 0;
      ur_en = -1; ur_rdy = -1; after_ur_en = -1;
      prev_en = 0; seen_frame = 0; ur_pending = 0;
      for (int i = 0; i < N; i++) begin n_rdy[i] = 0; n_cons[i] = 0; end
      glog.delete();
   endtask

   task automatic clear_src();
      for (int i = 0; i < N; i++) begin
         active[i] = 0; pos[i] = 0; len[i] = 0; drop_at[i] = NONE;
         frames_left[i] = 0; no_last[i] = 0;
      end
      acked = 0; en_cnt = 0; tx_ack = 1'b0;
   endtask

   task automatic start_src(input int i, input int unsigned l, input int unsigned frames,
                            input int unsigned drop, input bit nolast);
      active[i] = 1; pos[i] = 0; len[i] = l; frames_left[i] = frames;
      drop_at[i] = drop; no_last[i] = nolast;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_src();
      drive();
      @(posedge tx_clk);
      @(posedge tx_clk);
      #1;
      rst_n = 1'b1;
      clear_stats();
   endtask

   // One clock: sample mid-cycle, then advance sources and ack after the edge.
   task automatic tick();
      int g;
      @(negedge tx_clk);
      s_en = tx_data_en; s_data = tx_data; s_rdy = req_ready; s_grant = grant;
      s_ur = tx_underrun; s_busy = busy; s_valid = req_valid;
      g = -1;
      for (int i = 0; i < N; i++) if (s_grant[i]) g = i;
      if (s_en) n_en++;
      if (s_busy) n_busy++;
      if (ur_pending) begin after_ur_en = int'(s_en); ur_pending = 0; end
      if (s_ur) begin
         n_ur++; ur_en = int'(s_en); ur_pending = 1;
         ur_rdy = (g >= 0) ? int'(s_rdy[g]) : 0;
      end
      if (s_en && !prev_en) begin
         glog.push_back(s_grant);
         if (seen_frame && low_run < min_gap) min_gap = low_run;
         frame_bytes = 0;
      end
      if (s_en) begin low_run = 0; seen_frame = 1; end
      else low_run++;
      prev_en = s_en;
      if (s_en && g >= 0 && frame_bytes == 0) begin
         n_wait++;
         if (s_data !== byte_of(g, 0)) n_bad++;
      end
      for (int i = 0; i < N; i++) begin
         if (s_rdy[i]) n_rdy[i]++;
         if (s_rdy[i] && s_valid[i]) begin
            n_cons[i]++;
            if (s_data !== byte_of(i, pos[i])) n_bad++;
            if (i == g) frame_bytes++;
         end
      end
      @(posedge tx_clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (s_rdy[i] && s_valid[i]) begin
            bit was_last;
            was_last = !no_last[i] && (pos[i] == len[i] - 1);
            pos[i]++;
            if (was_last) begin
               pos[i] = 0;
               frames_left[i]--;
               if (frames_left[i] == 0) active[i] = 0;
            end
         end
         if (s_ur && s_grant[i]) begin active[i] = 0; pos[i] = 0; end
      end
      if (tx_data_en) begin
         if (!acked) en_cnt++;
         tx_ack = !acked && (en_cnt == ack_delay);
         if (tx_ack) acked = 1;
      end else begin
         en_cnt = 0; acked = 0; tx_ack = 1'b0;
      end
      drive();
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (grant !== '0) begin $display("FAIL reset_grant: got %b want 00", grant); n_err++; end
      n_vec++; if (tx_data_en !== 1'b0) begin $display("FAIL reset_en: got %b want 0", tx_data_en); n_err++; end
      n_vec++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_err++; end
      n_vec++; if (tx_underrun !== 1'b0) begin $display("FAIL reset_underrun: got %b want 0", tx_underrun); n_err++; end
      n_vec++; if (tx_data !== 8'h00) begin $display("FAIL reset_data: got %h want 00", tx_data); n_err++; end
`ifdef ETH_TX_ARB_STATS_EN
      n_vec++; if (frame_cnt !== '0 || underrun_cnt !== 16'd0) begin
         $display("FAIL reset_stats: got %h/%h want 0/0", frame_cnt, underrun_cnt); n_err++; end
`endif
   endtask

   task automatic test_single_frame();
      do_reset();
      ack_delay = 3;
      start_src(0, 60, 1, NONE, 0);
      drive();
      repeat (80) tick();
      n_vec++; if (n_wait !== 3) begin $display("FAIL single_first_hold: got %0d want 3", n_wait); n_err++; end
      n_vec++; if (n_cons[0] !== 60) begin $display("FAIL single_bytes: got %0d want 60", n_cons[0]); n_err++; end
      n_vec++; if (n_en !== 62) begin $display("FAIL single_en_cycles: got %0d want 62", n_en); n_err++; end
      n_vec++; if (n_busy !== 67) begin $display("FAIL single_busy_cycles: got %0d want 67", n_busy); n_err++; end
      n_vec++; if (n_bad !== 0) begin $display("FAIL single_data: got %0d bad bytes want 0", n_bad); n_err++; end
      n_vec++; if (n_ur !== 0) begin $display("FAIL single_underrun: got %0d want 0", n_ur); n_err++; end
      n_vec++; if (s_busy !== 1'b0) begin $display("FAIL single_busy_end: got %b want 0", s_busy); n_err++; end
`ifdef ETH_TX_ARB_STATS_EN
      n_vec++; if (frame_cnt[15:0] !== 16'd1) begin $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt[15:0]); n_err++; end
`endif
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] exp_g[4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      do_reset();
      ack_delay = 1;
      start_src(0, 64, 2, NONE, 0);
      start_src(1, 64, 2, NONE, 0);
      drive();
      repeat (300) tick();
      n_vec++; if (glog.size() !== 4) begin $display("FAIL b2b_frames: got %0d want 4", glog.size()); n_err++; end
      for (int k = 0; k < 4; k++) begin
         logic [N-1:0] got;
         got = (k < glog.size()) ? glog[k] : '0;
         n_vec++; if (got !== exp_g[k]) begin $display("FAIL b2b_grant%0d: got %b want %b", k, got, exp_g[k]); n_err++; end
      end
      n_vec++; if (min_gap !== 6) begin $display("FAIL b2b_min_gap: got %0d want 6", min_gap); n_err++; end
      n_vec++; if (n_cons[0] !== 128 || n_cons[1] !== 128) begin
         $display("FAIL b2b_bytes: got %0d/%0d want 128/128", n_cons[0], n_cons[1]); n_err++; end
      n_vec++; if (n_en !== 256) begin $display("FAIL b2b_en_cycles: got %0d want 256", n_en); n_err++; end
      n_vec++; if (n_bad !== 0) begin $display("FAIL b2b_data: got %0d bad bytes want 0", n_bad); n_err++; end
      n_vec++; if (n_ur !== 0) begin $display("FAIL b2b_underrun: got %0d want 0", n_ur); n_err++; end
`ifdef ETH_TX_ARB_STATS_EN
      n_vec++; if (frame_cnt !== {16'd2, 16'd2}) begin $display("FAIL b2b_frame_cnt: got %h want 00020002", frame_cnt); n_err++; end
`endif
   endtask

   task automatic test_underrun();
      do_reset();
      ack_delay = 1;
      start_src(1, 64, 1, 20, 0);
      drive();
      repeat (40) tick();
      n_vec++; if (n_ur !== 1) begin $display("FAIL ur_pulses: got %0d want 1", n_ur); n_err++; end
      n_vec++; if (ur_en !== 1) begin $display("FAIL ur_en_same_cycle: got %0d want 1", ur_en); n_err++; end
      n_vec++; if (after_ur_en !== 0) begin $display("FAIL ur_en_next_cycle: got %0d want 0", after_ur_en); n_err++; end
      n_vec++; if (n_cons[1] !== 20) begin $display("FAIL ur_bytes: got %0d want 20", n_cons[1]); n_err++; end
      n_vec++; if (n_en !== 21) begin $display("FAIL ur_en_cycles: got %0d want 21", n_en); n_err++; end
      n_vec++; if (s_busy !== 1'b0) begin $display("FAIL ur_busy_end: got %b want 0", s_busy); n_err++; end
`ifdef ETH_TX_ARB_STATS_EN
      n_vec++; if (underrun_cnt !== 16'd1) begin $display("FAIL ur_count: got %0d want 1", underrun_cnt); n_err++; end
      n_vec++; if (frame_cnt[31:16] !== 16'd0) begin $display("FAIL ur_frame_cnt: got %0d want 0", frame_cnt[31:16]); n_err++; end
`endif
   endtask

   task automatic test_max_len();
      do_reset();
      ack_delay = 1;
      start_src(0, 1515, 1, NONE, 1);
      drive();
      repeat (1540) tick();
      n_vec++; if (n_ur !== 1) begin $display("FAIL max_pulses: got %0d want 1", n_ur); n_err++; end
      n_vec++; if (n_cons[0] !== 1514) begin $display("FAIL max_bytes: got %0d want 1514", n_cons[0]); n_err++; end
      n_vec++; if (ur_rdy !== 0) begin $display("FAIL max_no_take: got ready %0d want 0", ur_rdy); n_err++; end
      n_vec++; if (n_en !== 1515) begin $display("FAIL max_en_cycles: got %0d want 1515", n_en); n_err++; end
      n_vec++; if (s_grant !== '0 || s_busy !== 1'b0) begin
         $display("FAIL max_release: got grant %b busy %b want 00/0", s_grant, s_busy); n_err++; end
   endtask

   task automatic test_one_byte();
      do_reset();
      ack_delay = 2;
      start_src(0, 1, 1, NONE, 0);
      drive();
      repeat (20) tick();
      n_vec++; if (n_rdy[0] !== 1) begin $display("FAIL one_ready_pulses: got %0d want 1", n_rdy[0]); n_err++; end
      n_vec++; if (n_en !== 2) begin $display("FAIL one_en_cycles: got %0d want 2", n_en); n_err++; end
      n_vec++; if (n_busy !== 7) begin $display("FAIL one_busy_cycles: got %0d want 7", n_busy); n_err++; end
      n_vec++; if (n_ur !== 0 || n_bad !== 0) begin $display("FAIL one_clean: got ur %0d bad %0d want 0/0", n_ur, n_bad); n_err++; end
`ifdef ETH_TX_ARB_STATS_EN
      n_vec++; if (frame_cnt[15:0] !== 16'd1) begin $display("FAIL one_frame_cnt: got %0d want 1", frame_cnt[15:0]); n_err++; end
`endif
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] first;
      do_reset();
      ack_delay = 1;
      start_src(0, 64, 1, NONE, 0);
      drive();
      repeat (30) tick();
      n_vec++; if (tx_data_en !== 1'b1) begin $display("FAIL mid_streaming: got %b want 1", tx_data_en); n_err++; end
      rst_n = 1'b0;
      #1;
      n_vec++; if (grant !== '0 || tx_data_en !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL mid_reset_outs: got grant %b en %b busy %b want 00/0/0", grant, tx_data_en, busy); n_err++; end
      n_vec++; if (tx_data !== 8'h00 || req_ready !== '0 || tx_underrun !== 1'b0) begin
         $display("FAIL mid_reset_comb: got data %h ready %b ur %b want 00/00/0", tx_data, req_ready, tx_underrun); n_err++; end
      clear_src();
      drive();
      @(posedge tx_clk);
      @(posedge tx_clk);
      #1;
      rst_n = 1'b1;
      clear_stats();
      ack_delay = 1;
      start_src(0, 8, 1, NONE, 0);
      start_src(1, 8, 1, NONE, 0);
      drive();
      repeat (12) tick();
      first = (glog.size() > 0) ? glog[0] : '0;
      n_vec++; if (first !== 2'b01) begin $display("FAIL mid_first_winner: got %b want 01", first); n_err++; end
   endtask

   initial begin
      rst_n     = 1'b0;
      tx_ack    = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      ack_delay = 1;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_underrun();
      test_max_len();
      test_one_byte();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
